motor_cmd_sequencer: RTL and testbench
======================================

Name: motor_cmd_sequencer

Overview:
- Command-level controller that drives the signed 12-bit left/right speed inputs of the motor-drive block (duty scaling + PWM) in the maze robot.
- Accepts move commands (stop, forward, spin left, spin right) over a valid/ready handshake.
- Ramps wheel speed magnitude up to the target, holds it for a commanded number of cycles, ramps back down to zero, then signals done.
- Emergency stop forces both wheels to zero immediately.

Parameters:
- RAMP_STEP, 8, magnitude increment/decrement per ramp tick (1..2047)
- RAMP_DIV, 4, clocks per ramp tick (>=1)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cmd_vld  input  1  command valid
- cmd_rdy  output  1  block can accept a command
- cmd_op  input  2  00 stop, 01 forward, 10 spin left, 11 spin right
- cmd_spd  input  11  unsigned target magnitude, 0..2047
- cmd_dur  input  16  hold duration in cycles
- estop  input  1  emergency stop, level-sensitive
- lft_spd  output  12  signed left wheel speed to motor drive
- rght_spd  output  12  signed right wheel speed to motor drive
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse on normal completion

Behaviour:
- Decided: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, mag=0, lft_spd=0, rght_spd=0, busy=0, done=0. cmd_rdy=1 after reset unless estop is high.
- Internal registers:
  - mag: 11-bit unsigned magnitude.
  - tgt: 11 bits.
  - dur_cnt: 16 bits.
  - pre: prescaler, 0..RAMP_DIV-1.
  - sgn_l, sgn_r: sign bits.
- Output mapping (registered, from mag):
  - lft_spd = sgn_l ? -{0,mag} : {0,mag}; same rule for rght_spd with sgn_r.
  - Range is ±2047; 12'h800 is never produced.
- Signs by cmd_op:
  - forward: sgn_l=0, sgn_r=0
  - spin left: sgn_l=1, sgn_r=0
  - spin right: sgn_l=0, sgn_r=1
- cmd_rdy = (state==IDLE) && !estop. A command is accepted on a clk edge with cmd_vld && cmd_rdy.
- On accept: latch tgt=cmd_spd, dur_cnt=cmd_dur, signs; clear pre.
  - op=stop goes to RAMP_DN.
  - Any other op goes to RAMP_UP.
- Ramp tick: pre increments each cycle in RAMP_UP/RAMP_DN and wraps at RAMP_DIV-1. A tick occurs on the edge where pre==RAMP_DIV-1. pre clears on every state change.
- RAMP_UP:
  - If mag==tgt at the start of a cycle, go to HOLD next edge (no tick needed).
  - Otherwise, on each tick: mag = min(mag+RAMP_STEP, tgt). Compute the sum at 12 bits so there is no wrap.
- HOLD:
  - If dur_cnt==0, go to RAMP_DN; else dur_cnt decrements.
  - HOLD therefore lasts cmd_dur+1 cycles. mag is unchanged.
- RAMP_DN:
  - If mag==0, go to IDLE and assert done for exactly that one cycle (done=1 while state becomes IDLE).
  - Otherwise, on each tick: mag = max(mag-RAMP_STEP, 0) (saturate, no underflow).
- Signs hold their values until the next accept, so output polarity is constant through ramp-down.
- estop:
  - Has priority over everything except rst.
  - When sampled high on an edge: mag=0, state=IDLE, pre=0, dur_cnt=0, no done pulse.
  - Outputs read 0 in the cycle after estop is sampled.
  - cmd_rdy stays low while estop=1; commands presented then are ignored.
- cmd_spd=0: RAMP_UP exits on the first cycle, HOLD runs, RAMP_DN exits on its first cycle, then done.
- cmd_vld while busy: ignored and not queued; the source must hold it until cmd_rdy.
- rst mid-operation: immediate return to reset values on the next edge; no done pulse.

Test Plan:
- Reset, then forward (op=01, spd=16, dur=3) -> after accept:
  - lft_spd and rght_spd = 0 for 4 cycles, 8 for 4 cycles, then 16.
  - HOLD lasts 4 cycles, then 8, then 0.
  - One-cycle done pulse when state returns to IDLE; busy falls the same cycle.
- Spin left (op=10, spd=20, dur=0), defaults:
  - lft_spd steps -8, -16, -20 (last step clamps); rght_spd steps +8, +16, +20.
  - Ramp-down steps 12, 4, 0 with signs preserved.
- Saturation: RAMP_STEP=2047, spd=2047 -> mag reaches 2047 in one tick. lft_spd=12'h7FF; on spin right rght_spd=-2047 (12'h801), never 12'h800.
- estop asserted mid-HOLD at spd=16 -> next cycle both outputs 0, busy=0, no done pulse, cmd_rdy=0 until estop falls, then cmd_rdy=1.
- Handshake:
  - cmd_vld held high through an entire forward command -> exactly one accept; a second accept occurs only after done.
  - cmd_vld pulsed while busy -> ignored.
- Edge cases:
  - Stop command in IDLE -> done pulse 2 cycles after accept, outputs remain 0.
  - cmd_spd=0 forward with dur=2 -> done after HOLD of 3 cycles.
  - rst mid-RAMP_UP -> all outputs 0 next edge.

Source files
------------

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer
// Command-level wheel speed controller for the maze robot motor drive.
// Each accepted move command ramps the wheel speed magnitude up to a target,
// holds it for a commanded number of cycles, ramps it back down to zero and
// pulses done. An emergency stop zeroes both wheels immediately.
module motor_cmd_sequencer #(
  parameter int RAMP_STEP = 8,
  parameter int RAMP_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [1:0]  cmd_op,
  input  logic [10:0] cmd_spd,
  input  logic [15:0] cmd_dur,
  input  logic        estop,
  output logic [11:0] lft_spd,
  output logic [11:0] rght_spd,
  output logic        busy,
  output logic        done
);

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(RAMP_DIV - 1);
  localparam logic [11:0] STEP12 = 12'(RAMP_STEP);

  localparam logic [1:0] OP_STOP  = 2'b00;
  localparam logic [1:0] OP_SPINL = 2'b10;
  localparam logic [1:0] OP_SPINR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    HOLD    = 2'd2,
    RAMP_DN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [10:0]      mag_q, mag_d;
  logic [10:0]      tgt_q, tgt_d;
  logic [15:0]      dur_cnt_q, dur_cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             sgn_l_q, sgn_l_d;
  logic             sgn_r_q, sgn_r_d;
  logic             done_q, done_d;
  logic [11:0]      lft_spd_q, lft_spd_d;
  logic [11:0]      rght_spd_q, rght_spd_d;

  logic             tick;
  logic             accept;
  logic [11:0]      up_sum;
  logic [11:0]      dn_diff;
  logic [11:0]      mag_ext_d;

  // The ramp arithmetic is done one bit wider than the magnitude so that the
  // upward sum cannot wrap and the downward difference can be range-checked.
  assign tick      = (pre_q == PRE_MAX);
  assign up_sum    = {1'b0, mag_q} + STEP12;
  assign dn_diff   = {1'b0, mag_q} - STEP12;
  assign mag_ext_d = {1'b0, mag_d};

  assign cmd_rdy  = (state_q == IDLE) && !estop;
  assign accept   = cmd_vld && cmd_rdy;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign lft_spd  = lft_spd_q;
  assign rght_spd = rght_spd_q;

  // Next-state logic: command accept, ramp ticks, hold countdown, emergency stop override.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    tgt_d     = tgt_q;
    dur_cnt_d = dur_cnt_q;
    pre_d     = pre_q;
    sgn_l_d   = sgn_l_q;
    sgn_r_d   = sgn_r_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d     = cmd_spd;
          dur_cnt_d = cmd_dur;
          pre_d     = '0;
          sgn_l_d   = (cmd_op == OP_SPINL);
          sgn_r_d   = (cmd_op == OP_SPINR);
          state_d   = (cmd_op == OP_STOP) ? RAMP_DN : RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (mag_q == tgt_q) begin
          state_d = HOLD;
          pre_d   = '0;
        end else begin
          pre_d = tick ? '0 : pre_q + PRE_W'(1);
          if (tick) begin
            mag_d = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[10:0];
          end
        end
      end
      HOLD: begin
        if (dur_cnt_q == 16'd0) begin
          state_d = RAMP_DN;
          pre_d   = '0;
        end else begin
          dur_cnt_d = dur_cnt_q - 16'd1;
        end
      end
      RAMP_DN: begin
        if (mag_q == 11'd0) begin
          state_d = IDLE;
          pre_d   = '0;
          done_d  = 1'b1;
        end else begin
          pre_d = tick ? '0 : pre_q + PRE_W'(1);
          if (tick) begin
            mag_d = ({1'b0, mag_q} > STEP12) ? dn_diff[10:0] : 11'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (estop) begin
      state_d   = IDLE;
      mag_d     = 11'd0;
      pre_d     = '0;
      dur_cnt_d = 16'd0;
      done_d    = 1'b0;
    end
  end

  // Signed wheel speeds follow the next magnitude so outputs update with it.
  always_comb begin
    lft_spd_d  = sgn_l_d ? (12'd0 - mag_ext_d) : mag_ext_d;
    rght_spd_d = sgn_r_d ? (12'd0 - mag_ext_d) : mag_ext_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mag_q      <= 11'd0;
      tgt_q      <= 11'd0;
      dur_cnt_q  <= 16'd0;
      pre_q      <= '0;
      sgn_l_q    <= 1'b0;
      sgn_r_q    <= 1'b0;
      done_q     <= 1'b0;
      lft_spd_q  <= 12'd0;
      rght_spd_q <= 12'd0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      tgt_q      <= tgt_d;
      dur_cnt_q  <= dur_cnt_d;
      pre_q      <= pre_d;
      sgn_l_q    <= sgn_l_d;
      sgn_r_q    <= sgn_r_d;
      done_q     <= done_d;
      lft_spd_q  <= lft_spd_d;
      rght_spd_q <= rght_spd_d;
    end
  end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb_motor_cmd_sequencer
// Drives two sequencers (default ramp and a single-tick saturating ramp) with
// identical stimulus and compares each against a trajectory model that derives
// the expected magnitude from elapsed cycles since command accept.
module tb_motor_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vld;
  logic [1:0]  cmd_op;
  logic [10:0] cmd_spd;
  logic [15:0] cmd_dur;
  logic        estop;

  logic        rdy0, busy0, done0;
  logic        rdy1, busy1, done1;
  logic [11:0] lft0, rght0, lft1, rght1;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  int mStep [2] = '{8, 2047};
  int mDiv  [2] = '{4, 2};
  int mOp   [2];
  int mSpd  [2];
  int mDur  [2];
  int mK    [2];
  bit mBusy [2];
  bit mDone [2];
  bit mSgnL [2];
  bit mSgnR [2];

  int rOp, rSpd, rDur, estopLeft;

  always #5 clk = ~clk;

  motor_cmd_sequencer u_dut0 (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(rdy0), .cmd_op(cmd_op),
    .cmd_spd(cmd_spd), .cmd_dur(cmd_dur), .estop(estop), .lft_spd(lft0),
    .rght_spd(rght0), .busy(busy0), .done(done0)
  );

  motor_cmd_sequencer #(.RAMP_STEP(2047), .RAMP_DIV(2)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(rdy1), .cmd_op(cmd_op),
    .cmd_spd(cmd_spd), .cmd_dur(cmd_dur), .estop(estop), .lft_spd(lft1),
    .rght_spd(rght1), .busy(busy1), .done(done1)
  );

  // Magnitude k cycles after accept, or -1 once the command has completed.
  function automatic int expMag(int i, int k);
    int nTicks, lu, lh, ld, t, v;
    if (mOp[i] == 0) return (k == 0) ? 0 : -1;
    nTicks = (mSpd[i] + mStep[i] - 1) / mStep[i];
    lu = nTicks * mDiv[i] + 1;
    lh = mDur[i] + 1;
    ld = nTicks * mDiv[i] + 1;
    if (k < lu) begin
      t = k / mDiv[i];
      v = t * mStep[i];
      return (v > mSpd[i]) ? mSpd[i] : v;
    end
    if (k < lu + lh) return mSpd[i];
    if (k < lu + lh + ld) begin
      t = (k - lu - lh) / mDiv[i];
      v = mSpd[i] - t * mStep[i];
      return (v < 0) ? 0 : v;
    end
    return -1;
  endfunction

  // Advance model i to the state expected after the coming clock edge.
  task automatic modelStep(input int i);
    if (rst) begin
      mBusy[i] = 1'b0;
      mDone[i] = 1'b0;
      mSgnL[i] = 1'b0;
      mSgnR[i] = 1'b0;
      mK[i]    = 0;
    end else if (estop) begin
      mBusy[i] = 1'b0;
      mDone[i] = 1'b0;
    end else if (mBusy[i]) begin
      mK[i] = mK[i] + 1;
      if (expMag(i, mK[i]) < 0) begin
        mBusy[i] = 1'b0;
        mDone[i] = 1'b1;
      end else begin
        mDone[i] = 1'b0;
      end
    end else begin
      mDone[i] = 1'b0;
      if (cmd_vld) begin
        mOp[i]   = int'(cmd_op);
        mSpd[i]  = int'(cmd_spd);
        mDur[i]  = int'(cmd_dur);
        mK[i]    = 0;
        mBusy[i] = 1'b1;
        mSgnL[i] = (cmd_op == 2'b10);
        mSgnR[i] = (cmd_op == 2'b11);
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total = total + 1;
    if (observed != expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", tag, cycle, observed, expected);
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 2; i++) begin
      int m, expL, expR, obsL, obsR, obsB, obsD, obsRdy;
      m    = mBusy[i] ? expMag(i, mK[i]) : 0;
      expL = mSgnL[i] ? -m : m;
      expR = mSgnR[i] ? -m : m;
      obsL   = (i == 0) ? int'($signed(lft0))  : int'($signed(lft1));
      obsR   = (i == 0) ? int'($signed(rght0)) : int'($signed(rght1));
      obsB   = (i == 0) ? int'(busy0) : int'(busy1);
      obsD   = (i == 0) ? int'(done0) : int'(done1);
      obsRdy = (i == 0) ? int'(rdy0)  : int'(rdy1);
      checkOutput($sformatf("u%0d.lft_spd", i), obsL, expL);
      checkOutput($sformatf("u%0d.rght_spd", i), obsR, expR);
      checkOutput($sformatf("u%0d.busy", i), obsB, int'(mBusy[i]));
      checkOutput($sformatf("u%0d.done", i), obsD, int'(mDone[i]));
      checkOutput($sformatf("u%0d.cmd_rdy", i), obsRdy, int'(!mBusy[i] && !estop));
    end
  endtask

  // One clock: drive inputs, predict, let the edge happen, then compare.
  task automatic applyStimulus(input bit r, input bit e, input bit v, input int op,
                               input int spd, input int dur);
    rst     = r;
    estop   = e;
    cmd_vld = v;
    cmd_op  = 2'(op);
    cmd_spd = 11'(spd);
    cmd_dur = 16'(dur);
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
    cycle = cycle + 1;
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((mBusy[0] || mBusy[1]) && n < budget) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      n++;
    end
    if (mBusy[0] || mBusy[1]) checkOutput("idle_timeout", 1, 0);
  endtask

  task automatic issue(input int op, input int spd, input int dur);
    applyStimulus(0, 0, 1, op, spd, dur);
    waitIdle(20000);
    idleCycles(2);
  endtask

  initial begin
    rst = 1'b1; estop = 1'b0; cmd_vld = 1'b0;
    cmd_op = 2'd0; cmd_spd = 11'd0; cmd_dur = 16'd0;
    $display("[TB] start");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    idleCycles(2);

    issue(1, 16, 3);
    issue(2, 20, 0);
    issue(1, 2047, 1);
    issue(3, 2047, 2);
    issue(0, 0, 0);
    issue(1, 0, 2);
    issue(3, 5, 0);

    // Command held valid across several completions.
    for (int c = 0; c < 90; c++) applyStimulus(0, 0, 1, 1, 16, 3);
    waitIdle(20000);
    idleCycles(2);

    // Valid pulsed while busy must be ignored.
    applyStimulus(0, 0, 1, 1, 24, 4);
    idleCycles(5);
    applyStimulus(0, 0, 1, 2, 40, 9);
    idleCycles(3);
    applyStimulus(0, 0, 1, 3, 40, 9);
    waitIdle(20000);
    idleCycles(2);

    // Emergency stop in the middle of hold, with a command offered meanwhile.
    applyStimulus(0, 0, 1, 1, 16, 20);
    idleCycles(12);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 30, 2);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(3);

    // Reset in the middle of ramp-up.
    applyStimulus(0, 0, 1, 2, 200, 5);
    idleCycles(10);
    applyStimulus(1, 0, 0, 0, 0, 0);
    idleCycles(3);

    estopLeft = 0;
    rOp = 1; rSpd = 10; rDur = 1;
    for (int n = 0; n < 25000; n++) begin
      bit r, e, v;
      int sel;
      r = ($urandom_range(0, 699) == 0);
      if (estopLeft > 0) estopLeft--;
      else if ($urandom_range(0, 149) == 0) estopLeft = $urandom_range(1, 5);
      e = (estopLeft > 0);
      if ($urandom_range(0, 3) == 0) begin
        rOp = $urandom_range(0, 3);
        sel = $urandom_range(0, 19);
        if (sel == 0) rSpd = 2047;
        else if (sel < 3) rSpd = $urandom_range(0, 2047);
        else rSpd = $urandom_range(0, 48);
        rDur = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 6);
      end
      v = ($urandom_range(0, 2) != 0);
      applyStimulus(r, e, v, rOp, rSpd, rDur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
